// File: rtl/if_fetch_pc.sv
// Program counter and fetch-request unit at the head of the IF stage.
// Presents the next word address to a 1-cycle-latency instruction ROM and tracks the PC on its output.
module if_fetch_pc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned ROM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_ce,
    output logic [13:0] im_addr,
    output logic [31:0] pc_if,
    output logic        valid_if,
    output logic        fetch_err
);

    localparam logic [31:0] WIN_END = RESET_PC + 32'(4 * ROM_WORDS);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] npc;
    logic        fault;
    logic        ce;

    // Next fetch address, fault check and ROM enable
    always_comb begin
        npc = fetch_pc_q;
        if (rst) begin
            npc = RESET_PC;
        end else if (redirect && !stall) begin
            npc = redirect_pc;
        end else if (valid_q) begin
            npc = fetch_pc_q + 32'd4;
        end
        fault = (npc[1:0] != 2'b00) || (npc < RESET_PC) || (npc >= WIN_END);
        ce    = !rst && !stall && (!err_q || redirect) && !fault;
    end

    // State update: stall holds everything, a fault parks pc_if on the bad address
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        if (stall) begin
            fetch_pc_d = fetch_pc_q;
        end else if (fault) begin
            fetch_pc_d = npc;
            valid_d    = 1'b0;
            err_d      = 1'b1;
        end else if (ce) begin
            fetch_pc_d = npc;
            valid_d    = 1'b1;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign im_ce     = ce;
    assign im_addr   = npc[15:2];
    assign pc_if     = fetch_pc_q;
    assign valid_if  = valid_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_if_fetch_pc.sv
// Self-checking bench for if_fetch_pc: per-cycle stimulus with expected ROM request checked
// combinationally and expected IF state queued for comparison after the clock edge.
module tb_if_fetch_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        im_ce;
    logic [13:0] im_addr;
    logic [31:0] pc_if;
    logic        valid_if;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        sb_q[$];

    if_fetch_pc #(
        .RESET_PC (32'h0000_3000),
        .ROM_WORDS(2048)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .im_ce      (im_ce),
        .im_addr    (im_addr),
        .pc_if      (pc_if),
        .valid_if   (valid_if),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check the ROM request, then check the registered state after the edge
    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                         input logic e_ce, input logic [13:0] e_addr,
                         input logic [31:0] e_pc, input logic e_v, input logic e_err);
        exp_t e;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        check("im_ce", 32'(im_ce), 32'(e_ce));
        check("im_addr", 32'(im_addr), 32'(e_addr));
        e.pc    = e_pc;
        e.valid = e_v;
        e.err   = e_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("pc_if", pc_if, e.pc);
            check("valid_if", 32'(valid_if), 32'(e.valid));
            check("fetch_err", 32'(fetch_err), 32'(e.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //     rst s rd rpc            ce addr      pc_if          v  err
        cycle(1, 0, 0, 32'h0,        0, 14'hC00,  32'h3000, 0, 0);
        cycle(1, 0, 0, 32'h0,        0, 14'hC00,  32'h3000, 0, 0);
        // start-up and sequential fetch
        cycle(0, 0, 0, 32'h0,        1, 14'hC00,  32'h3000, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC01,  32'h3004, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC02,  32'h3008, 1, 0);
        // stall for three cycles
        cycle(0, 1, 0, 32'h0,        0, 14'hC03,  32'h3008, 1, 0);
        cycle(0, 1, 0, 32'h0,        0, 14'hC03,  32'h3008, 1, 0);
        cycle(0, 1, 0, 32'h0,        0, 14'hC03,  32'h3008, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC03,  32'h300C, 1, 0);
        // redirect without stall
        cycle(0, 0, 1, 32'h3100,     1, 14'hC40,  32'h3100, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC41,  32'h3104, 1, 0);
        // redirect held through a stall
        cycle(0, 1, 1, 32'h3200,     0, 14'hC42,  32'h3104, 1, 0);
        cycle(0, 1, 1, 32'h3200,     0, 14'hC42,  32'h3104, 1, 0);
        cycle(0, 0, 1, 32'h3200,     1, 14'hC80,  32'h3200, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC81,  32'h3204, 1, 0);
        // misaligned target, sticky error, recovery
        cycle(0, 0, 1, 32'h3102,     0, 14'hC40,  32'h3102, 0, 1);
        cycle(0, 0, 0, 32'h0,        0, 14'hC40,  32'h3102, 0, 1);
        cycle(0, 0, 1, 32'h3000,     1, 14'hC00,  32'h3000, 1, 0);
        // out-of-window target above and below, stall while faulted
        cycle(0, 0, 1, 32'h6000,     0, 14'h1800, 32'h6000, 0, 1);
        cycle(0, 1, 0, 32'h0,        0, 14'h1800, 32'h6000, 0, 1);
        cycle(0, 0, 1, 32'h3000,     1, 14'hC00,  32'h3000, 1, 0);
        cycle(0, 0, 1, 32'h2FFC,     0, 14'hBFF,  32'h2FFC, 0, 1);
        // sequential overflow off the last legal word
        cycle(0, 0, 1, 32'h4FF8,     1, 14'h13FE, 32'h4FF8, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'h13FF, 32'h4FFC, 1, 0);
        cycle(0, 0, 0, 32'h0,        0, 14'h1400, 32'h5000, 0, 1);
        cycle(0, 0, 0, 32'h0,        0, 14'h1400, 32'h5000, 0, 1);
        cycle(0, 0, 1, 32'h4000,     1, 14'h1000, 32'h4000, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'h1001, 32'h4004, 1, 0);
        // reset mid-run overrides a pending stall and redirect
        cycle(1, 1, 1, 32'h3300,     0, 14'hC00,  32'h3000, 0, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC00,  32'h3000, 1, 0);
        cycle(0, 0, 0, 32'h0,        1, 14'hC01,  32'h3004, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
